// File: rtl/symbol_query_pkg.sv
// Shared encodings for the symbol lookup feeder: FSM states, result codes
// and the pad bytes stripped from the tail of a symbol field.
package symbol_query_pkg;

   typedef enum logic [2:0] {
      sIDLE,
      sCAPTURE,
      sQUERY,
      sWAIT,
      sCOLLECT,
      sDONE,
      sDRAIN
   } state_e;

   localparam logic [1:0] ST_HIT   = 2'b00;
   localparam logic [1:0] ST_MISS  = 2'b01;
   localparam logic [1:0] ST_TMO   = 2'b10;
   localparam logic [1:0] ST_SHORT = 2'b11;

   localparam logic [7:0] PAD_NUL = 8'h00;
   localparam logic [7:0] PAD_SPC = 8'h20;

   function automatic logic is_pad(input logic [7:0] b);
      return (b == PAD_NUL) || (b == PAD_SPC);
   endfunction

endpackage

// File: rtl/symbol_field_capture.sv
// Tracks byte position within a message, captures the symbol field and
// reports its length with trailing pad bytes stripped.
module symbol_field_capture
   import symbol_query_pkg::*;
#(
   parameter logic [7:0] pSymOffset = 8'd2,
   parameter logic [7:0] pBytesKey  = 8'd6
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start_i,
   input  logic                        byte_i,
   input  logic                        eof_i,
   input  logic [7:0]                  data_i,
   output logic [pBytesKey-1:0][7:0]   key_buf_o,
   output logic [7:0]                  len_o,
   output logic                        field_done_o,
   output logic                        short_o,
   output logic                        eof_seen_o
);

   logic [7:0]                cnt_q, cnt_d;
   logic [pBytesKey-1:0][7:0] buf_q, buf_d;
   logic                      eof_q, eof_d;
   logic [7:0]                pos, idx;
   logic                      take, in_field;

   // Decisions are made on the incoming byte, so the length is taken from
   // the next-state buffer to let the FSM act in the same cycle.
   always_comb begin
      take     = start_i | byte_i;
      pos      = start_i ? 8'd0 : cnt_q;
      idx      = pos - pSymOffset;
      in_field = take && (pos >= pSymOffset) && (idx < pBytesKey);
      buf_d    = start_i ? '0 : buf_q;
      for (int i = 0; i < int'(pBytesKey); i++) begin
         if (in_field && (idx == 8'(i))) buf_d[i] = data_i;
      end
      cnt_d        = take ? pos + 8'd1 : cnt_q;
      eof_d        = start_i ? eof_i : (eof_q | (take & eof_i));
      field_done_o = in_field && (idx == pBytesKey - 8'd1);
      short_o      = take && eof_i && !field_done_o;
      len_o        = '0;
      for (int i = 0; i < int'(pBytesKey); i++) begin
         if (!is_pad(buf_d[i])) len_o = 8'(i + 1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         buf_q <= '0;
         eof_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         buf_q <= buf_d;
         eof_q <= eof_d;
      end
   end

   assign key_buf_o  = buf_q;
   assign eof_seen_o = eof_q;

endmodule

// File: rtl/symbol_query.sv
// Captures a symbol from a framed byte stream, queries the serial hash map
// with the stripped key and returns the assembled value with a status code.
module symbol_query
   import symbol_query_pkg::*;
#(
   parameter logic [7:0] pSymOffset  = 8'd2,
   parameter logic [7:0] pBytesKey   = 8'd6,
   parameter logic [7:0] pBytesValue = 8'd2,
   parameter logic [7:0] pTimeout    = 8'd64
) (
   input  logic                       CLOCK,
   input  logic                       RESET,
   input  logic [7:0]                 in_data,
   input  logic                       in_valid,
   input  logic                       in_sof,
   input  logic                       in_eof,
   output logic                       in_ready,
   output logic [7:0]                 map_key,
   output logic                       map_query,
   input  logic                       map_found,
   input  logic                       map_notfound,
   input  logic [7:0]                 map_data,
   output logic                       out_valid,
   output logic [1:0]                 out_status,
   output logic [8*pBytesValue-1:0]   out_index
);

   state_e                    state_q, state_d;
   logic [7:0]                qidx_q, qidx_d;
   logic [7:0]                len_q, len_d;
   logic [7:0]                tmr_q, tmr_d;
   logic [7:0]                vcnt_q, vcnt_d;
   logic [1:0]                status_q, status_d;
   logic [8*pBytesValue-1:0]  index_q, index_d;

   logic                      acc, start, cap_byte;
   logic [pBytesKey-1:0][7:0] key_buf;
   logic [7:0]                fld_len;
   logic                      fld_done, fld_short, fld_eof;

   assign in_ready = (state_q == sIDLE) || (state_q == sCAPTURE) || (state_q == sDRAIN);
   assign acc      = in_valid && in_ready;
   assign start    = acc && in_sof;
   assign cap_byte = acc && !in_sof && (state_q == sCAPTURE);

   symbol_field_capture #(
      .pSymOffset (pSymOffset),
      .pBytesKey  (pBytesKey)
   ) u_cap (
      .clk          (CLOCK),
      .rst          (RESET),
      .start_i      (start),
      .byte_i       (cap_byte),
      .eof_i        (in_eof),
      .data_i       (in_data),
      .key_buf_o    (key_buf),
      .len_o        (fld_len),
      .field_done_o (fld_done),
      .short_o      (fld_short),
      .eof_seen_o   (fld_eof)
   );

   always_comb begin
      state_d   = state_q;
      qidx_d    = qidx_q;
      len_d     = len_q;
      tmr_d     = tmr_q;
      vcnt_d    = vcnt_q;
      status_d  = status_q;
      index_d   = index_q;
      map_query = 1'b0;
      map_key   = '0;
      out_valid = 1'b0;
      case (state_q)
         sIDLE, sCAPTURE, sDRAIN: begin
            if (fld_done) begin
               len_d  = fld_len;
               qidx_d = '0;
               if (fld_len == 8'd0) begin
                  state_d  = sDONE;
                  status_d = ST_MISS;
               end else begin
                  state_d = sQUERY;
               end
            end else if (fld_short) begin
               state_d  = sDONE;
               status_d = ST_SHORT;
            end else if (start) begin
               state_d = sCAPTURE;
            end else if ((state_q == sDRAIN) && acc && in_eof) begin
               state_d = sIDLE;
            end
         end
         sQUERY: begin
            // Gated by RESET so the map sees the query drop in the reset cycle.
            map_query = !RESET;
            for (int i = 0; i < int'(pBytesKey); i++) begin
               if (!RESET && (qidx_q == 8'(i))) map_key = key_buf[i];
            end
            qidx_d = qidx_q + 8'd1;
            if (qidx_q == len_q - 8'd1) begin
               state_d = sWAIT;
               tmr_d   = '0;
            end
         end
         sWAIT: begin
            if (map_found) begin
               index_d      = index_q << 8;
               index_d[7:0] = map_data;
               vcnt_d       = 8'd1;
               if (pBytesValue == 8'd1) begin
                  state_d  = sDONE;
                  status_d = ST_HIT;
               end else begin
                  state_d = sCOLLECT;
               end
            end else if (map_notfound) begin
               state_d  = sDONE;
               status_d = ST_MISS;
            end else if (tmr_q == pTimeout - 8'd1) begin
               state_d  = sDONE;
               status_d = ST_TMO;
            end else begin
               tmr_d = tmr_q + 8'd1;
            end
         end
         sCOLLECT: begin
            if (map_found) begin
               index_d      = index_q << 8;
               index_d[7:0] = map_data;
               if (vcnt_q == pBytesValue - 8'd1) begin
                  state_d  = sDONE;
                  status_d = ST_HIT;
               end else begin
                  vcnt_d = vcnt_q + 8'd1;
               end
            end else begin
               state_d  = sDONE;
               status_d = ST_TMO;
            end
         end
         sDONE: begin
            out_valid = 1'b1;
            state_d   = (fld_eof || (status_q == ST_SHORT)) ? sIDLE : sDRAIN;
         end
         default: state_d = sIDLE;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q  <= sIDLE;
         qidx_q   <= '0;
         len_q    <= '0;
         tmr_q    <= '0;
         vcnt_q   <= '0;
         status_q <= ST_HIT;
         index_q  <= '0;
      end else begin
         state_q  <= state_d;
         qidx_q   <= qidx_d;
         len_q    <= len_d;
         tmr_q    <= tmr_d;
         vcnt_q   <= vcnt_d;
         status_q <= status_d;
         index_q  <= index_d;
      end
   end

   assign out_status = status_q;
   assign out_index  = index_q;

endmodule

// File: tb/tb_symbol_query.sv
// Scoreboard bench for symbol_query: a small map model answers queries and
// expected results are queued as each message is driven.
module tb_symbol_query;
   import symbol_query_pkg::*;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0;
   logic        in_ready;
   logic [7:0]  map_key;
   logic        map_query;
   logic        map_found = 1'b0, map_notfound = 1'b0;
   logic [7:0]  map_data = '0;
   logic        out_valid;
   logic [1:0]  out_status;
   logic [15:0] out_index;

   symbol_query dut (
      .CLOCK        (CLOCK),
      .RESET        (RESET),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_sof       (in_sof),
      .in_eof       (in_eof),
      .in_ready     (in_ready),
      .map_key      (map_key),
      .map_query    (map_query),
      .map_found    (map_found),
      .map_notfound (map_notfound),
      .map_data     (map_data),
      .out_valid    (out_valid),
      .out_status   (out_status),
      .out_index    (out_index)
   );

   always #5 CLOCK = ~CLOCK;

   int cyc = 0;
   always @(posedge CLOCK) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]  st;
      logic [15:0] idx;
      bit          idx_chk;
      int          lat_mode;   // 0 none, 1 after last found, 2 after field, 3 timeout
   } exp_t;

   localparam int M_HIT = 0, M_MISS = 1, M_NONE = 2, M_DROP = 3, M_ABORT = 4;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_chk = 0, n_pass = 0;
   int          qcnt = 0, exp_len = 0, mode = M_NONE;
   logic [7:0]  exp_key[6];
   logic [7:0]  qk[$];
   logic [7:0]  rv0 = '0, rv1 = '0;
   int          last_found_cyc = 0, qend_cyc = 0, fld_cyc = 0;
   bit          prev_ov = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   task automatic push(input logic [1:0] st, input logic [15:0] idx, input bit ic, input int lm);
      exp_t e;
      e.st = st; e.idx = idx; e.idx_chk = ic; e.lat_mode = lm;
      sb.push_back(e);
   endtask

   // Result monitor
   always @(negedge CLOCK) begin
      if (!RESET && out_valid) begin
         chk("ov_double", {31'd0, prev_ov}, 0);
         if (sb.size() == 0) chk("ov_unexpected", 1, 0);
         else begin
            mon_e = sb.pop_front();
            chk("status", {30'd0, out_status}, {30'd0, mon_e.st});
            if (mon_e.idx_chk) chk("index", {16'd0, out_index}, {16'd0, mon_e.idx});
            case (mon_e.lat_mode)
               1: chk("lat_hit", cyc - last_found_cyc, 1);
               2: chk("lat_pad", cyc - fld_cyc, 1);
               3: chk("lat_tmo", cyc - qend_cyc, 64);
               default: ;
            endcase
         end
      end
      prev_ov <= out_valid;
   end

   // Map model: collects the key, then answers according to mode.
   initial begin
      forever begin
         @(negedge CLOCK);
         if (map_query) begin
            qk.push_back(map_key);
            qcnt++;
         end else if (qk.size() > 0) begin
            qend_cyc = cyc;
            if (mode != M_ABORT) begin
               chk("qlen", qk.size(), exp_len);
               for (int i = 0; i < qk.size() && i < 6; i++) chk("qkey", {24'd0, qk[i]}, {24'd0, exp_key[i]});
            end
            qk.delete();
            case (mode)
               M_HIT: begin
                  map_found = 1'b1; map_data = rv0;
                  @(negedge CLOCK);
                  map_data = rv1; last_found_cyc = cyc;
                  @(negedge CLOCK);
                  map_found = 1'b0; map_data = '0;
               end
               M_DROP: begin
                  map_found = 1'b1; map_data = rv0;
                  @(negedge CLOCK);
                  map_found = 1'b0; map_data = '0;
               end
               M_MISS: begin
                  repeat (2) @(negedge CLOCK);
                  map_notfound = 1'b1;
                  @(negedge CLOCK);
                  map_notfound = 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic s, input logic e, output int c);
      int n = 0;
      in_data = d; in_sof = s; in_eof = e; in_valid = 1'b1;
      while (!in_ready && n < 300) begin
         @(negedge CLOCK);
         n++;
      end
      if (!in_ready) chk("ready_timeout", 0, 1);
      c = cyc;
      @(negedge CLOCK);
      in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
   endtask

   task automatic send_sym(input logic [47:0] sym, input bit trail, input bit eof);
      int c;
      send(8'h41, 1'b1, 1'b0, c);
      send(8'h42, 1'b0, 1'b0, c);
      for (int i = 0; i < 6; i++) begin
         send(sym[47-8*i -: 8], 1'b0, (!trail && eof && i == 5), c);
         if (i == 5) fld_cyc = c;
      end
      if (trail) send(8'h0A, 1'b0, eof, c);
   endtask

   task automatic set_key(input logic [47:0] sym, input int len);
      for (int i = 0; i < 6; i++) exp_key[i] = sym[47-8*i -: 8];
      exp_len = len;
   endtask

   task automatic wait_sb();
      int n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(negedge CLOCK);
         n++;
      end
      if (sb.size() != 0) begin
         chk("result_timeout", sb.size(), 0);
         sb.delete();
      end
      repeat (2) @(negedge CLOCK);
   endtask

   initial begin
      int q0, c;
      logic [47:0] sym;
      repeat (3) @(negedge CLOCK);
      chk("rst_ready", {31'd0, in_ready}, 1);
      chk("rst_query", {31'd0, map_query}, 0);
      chk("rst_key", {24'd0, map_key}, 0);
      chk("rst_ovalid", {31'd0, out_valid}, 0);
      chk("rst_status", {30'd0, out_status}, 0);
      chk("rst_index", {16'd0, out_index}, 0);
      RESET = 1'b0;
      @(negedge CLOCK);

      // Hit with pad-stripped key, eof after the field
      mode = M_HIT; rv0 = 8'h01; rv1 = 8'h2C;
      sym = "VOD   "; set_key(sym, 3);
      push(ST_HIT, 16'h012C, 1'b1, 1);
      send_sym(sym, 1'b1, 1'b1);
      wait_sb();
      chk("idle_ready1", {31'd0, in_ready}, 1);

      // Miss leaves index untouched
      mode = M_MISS;
      sym = "MSFT  "; set_key(sym, 4);
      push(ST_MISS, 16'h012C, 1'b1, 0);
      send_sym(sym, 1'b1, 1'b1);
      wait_sb();

      // All-pad field: no query, immediate miss, trailer drained
      mode = M_NONE; q0 = qcnt;
      sym = {8'h20, 8'h00, 8'h20, 8'h20, 8'h00, 8'h20};
      push(ST_MISS, 16'h012C, 1'b1, 2);
      send_sym(sym, 1'b1, 1'b1);
      wait_sb();
      chk("pad_noquery", qcnt - q0, 0);

      // Full-width key, eof on the last field byte
      mode = M_HIT; rv0 = 8'hBE; rv1 = 8'hEF;
      sym = "AB1234"; set_key(sym, 6);
      push(ST_HIT, 16'hBEEF, 1'b1, 1);
      send_sym(sym, 1'b0, 1'b1);
      wait_sb();
      chk("idle_ready2", {31'd0, in_ready}, 1);

      // Short message: eof on byte 4
      q0 = qcnt;
      push(ST_SHORT, 16'hBEEF, 1'b1, 0);
      send(8'h41, 1'b1, 1'b0, c);
      send(8'h42, 1'b0, 1'b0, c);
      send(8'h58, 1'b0, 1'b0, c);
      send(8'h59, 1'b0, 1'b0, c);
      send(8'h5A, 1'b0, 1'b1, c);
      wait_sb();
      chk("short_noquery", qcnt - q0, 0);

      // Normal message after the short one; interior space kept, NUL tail stripped
      mode = M_HIT; rv0 = 8'h00; rv1 = 8'h07;
      sym = {8'h41, 8'h20, 8'h42, 8'h00, 8'h00, 8'h00}; set_key(sym, 3);
      push(ST_HIT, 16'h0007, 1'b1, 1);
      send_sym(sym, 1'b1, 1'b1);
      wait_sb();

      // Map never answers
      mode = M_NONE;
      sym = "TMO   "; set_key(sym, 3);
      push(ST_TMO, 16'h0000, 1'b0, 3);
      send_sym(sym, 1'b1, 1'b1);
      wait_sb();

      // found drops after one value byte
      mode = M_DROP; rv0 = 8'h55;
      sym = "DROP  "; set_key(sym, 4);
      push(ST_TMO, 16'h0000, 1'b0, 0);
      send_sym(sym, 1'b1, 1'b1);
      wait_sb();

      // Reset during the query, then a fresh lookup
      mode = M_ABORT;
      sym = "RST   ";
      send_sym(sym, 1'b0, 1'b0);
      chk("query_on", {31'd0, map_query}, 1);
      RESET = 1'b1;
      #1;
      chk("query_rst", {31'd0, map_query}, 0);
      @(negedge CLOCK);
      RESET = 1'b0;
      chk("rst2_ready", {31'd0, in_ready}, 1);
      chk("rst2_status", {30'd0, out_status}, 0);
      chk("rst2_index", {16'd0, out_index}, 0);
      repeat (2) @(negedge CLOCK);
      mode = M_HIT; rv0 = 8'h12; rv1 = 8'h34;
      sym = "NEW   "; set_key(sym, 3);
      push(ST_HIT, 16'h1234, 1'b1, 1);
      send_sym(sym, 1'b1, 1'b1);
      wait_sb();

      repeat (5) @(negedge CLOCK);
      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/symbol_query.md
Name: symbol_query

Overview:
- Upstream feeder for the serial hash-map lookup stage.
- Watches a framed byte stream of market messages and captures a fixed-width symbol field at a fixed byte offset. Trailing pad bytes are stripped.
- Presents the stripped key serially to the map (query/key), waits for found/notfound, and assembles the returned value bytes into one wide symbol index.
- Emits a single-cycle result with a status code.

Parameters:
pSymOffset, 8'd2, byte offset of the symbol field within a message; the start-of-frame byte is offset 0.
pBytesKey, 8'd6, symbol field width in bytes; must equal the map's key width.
pBytesValue, 8'd2, value width in bytes; must equal the map's value width.
pTimeout, 8'd64, maximum number of cycles to wait in sWAIT for found/notfound.

Ports:
CLOCK  in  1  system clock; all logic on the rising edge.
RESET  in  1  synchronous, active-high reset.
in_data  in  8  message byte.
in_valid  in  1  in_data is valid this cycle.
in_sof  in  1  first byte of a message; qualified by in_valid.
in_eof  in  1  last byte of a message; qualified by in_valid.
in_ready  out  1  this block accepts a byte this cycle.
map_key  out  8  serial key byte to the map.
map_query  out  1  high for exactly L consecutive cycles while key bytes are presented.
map_found  in  1  map hit; high while value bytes stream out.
map_notfound  in  1  map miss; one-cycle pulse.
map_data  in  8  value byte, sampled while map_found is high.
out_valid  out  1  one-cycle result strobe.
out_status  out  2  result code: 00 hit, 01 miss, 10 timeout/protocol error, 11 short message.
out_index  out  8*pBytesValue  assembled value, first received byte most significant; meaningful only on a hit.

Behaviour:
- Reset: state=sIDLE. in_ready=1. map_query=0, map_key=0. out_valid=0, out_status=0, out_index=0. Byte counter and key buffer are cleared.
- Byte transfer: a byte is accepted when in_valid && in_ready. in_ready=1 in sIDLE, sCAPTURE and sDRAIN, and 0 otherwise.
- Byte counter: 8 bits, 0 at the sof byte. Requirement: pSymOffset+pBytesKey <= 255.
- sIDLE:
  - Accepted byte with in_sof: counter=1; if pSymOffset==0, the byte is stored as key byte 0. Go to sCAPTURE.
  - Accepted byte without in_sof: ignored.
- sCAPTURE:
  - Store bytes with counter in [pSymOffset, pSymOffset+pBytesKey-1] into buf[counter-pSymOffset].
  - After the last field byte, compute L = 1 + index of the last byte that is neither 0x00 nor 0x20; L=0 if every byte is pad. Record whether eof has been seen. Go to sQUERY; if L==0, go to sDONE with status 01 and do not query the map.
  - in_eof before the field is complete: go to sDONE with status 11.
  - in_sof on any accepted byte restarts capture: counter reset, buffer cleared.
- sQUERY:
  - map_query=1 and map_key=buf[i] for i=0..L-1, one byte per cycle, no gaps.
  - The cycle after byte L-1: map_query=0, then go to sWAIT.
  - Pad bytes are never sent, because the map null-pads keys itself.
- sWAIT:
  - Timer counts up from 0.
  - map_notfound: go to sDONE with status 01.
  - map_found: shift map_data into out_index, byte count=1, go to sCOLLECT.
  - Timer reaches pTimeout: go to sDONE with status 10.
  - found and notfound in the same cycle: found wins.
- sCOLLECT:
  - Each cycle with map_found=1: shift in map_data. After pBytesValue bytes, go to sDONE with status 00.
  - map_found drops early: go to sDONE with status 10, out_index unspecified.
- sDONE (one cycle): out_valid=1 with out_status/out_index stable. Then:
  - if eof was already seen for this message, or status is 11: go to sIDLE;
  - otherwise: go to sDRAIN.
- Latency: on a hit, out_valid is high exactly one cycle after the last map_found cycle.
- sDRAIN: accept and discard bytes until an accepted byte has in_eof (then go to sIDLE). An accepted in_sof restarts capture as in sIDLE; that byte is the new message's byte 0.
- out_status and out_index hold their values until the next sDONE. out_valid is never high for two consecutive cycles.
- RESET mid-operation: map_query drops in the same cycle the reset is sampled. An abandoned map lookup completes inside the map unobserved: found/notfound are ignored outside sWAIT/sCOLLECT.

Decomposition:
- Shared package: state encodings (sIDLE, sCAPTURE, sQUERY, sWAIT, sCOLLECT, sDONE, sDRAIN), status codes (ST_HIT=2'b00, ST_MISS=2'b01, ST_TMO=2'b10, ST_SHORT=2'b11), pad constants 8'h00 and 8'h20.
- One natural sub-module: symbol_field_capture, holding the offset counter, key buffer and trailing-pad length computation, with outputs buf, L, field_done, short, eof_seen. The query/collect FSM stays in symbol_query.

Test Plan:
- Message bytes 0x41,0x42,"VOD   ",0x0A with eof on the last byte; map model returns found with 0x01,0x2C -> map_query high 3 cycles with "V","O","D"; out_valid with status 00 and out_index=16'h012C; direct return to sIDLE.
- Same framing, map model pulses notfound 2 cycles after query drops -> status 01, out_index unchanged from the previous result.
- Symbol field all 0x20 -> map_query never asserted; status 01 one cycle after the field completes; remaining bytes drained until eof.
- eof on message byte 4 (field incomplete) -> status 11, map_query never asserted; next message with sof is handled normally.
- Map model never responds -> status 10 after 64 cycles in sWAIT. A separate run drops found after 1 value byte -> status 10.
- RESET asserted during sQUERY, then a new message -> map_query low the same cycle; the new lookup returns a correct hit.
